// File: rtl/rbk_grp_pkg.sv
// Shared definitions for the RUBIK ping-pong group controller:
// status codes, FSM states, default group-space offsets and a status helper.
package rbk_grp_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } grp_state_e;

  localparam logic [11:0] DEF_OP_EN_OFFSET = 12'h008;
  localparam logic [11:0] DEF_GRP_FIRST    = 12'h008;
  localparam logic [11:0] DEF_GRP_LAST     = 12'h0FC;

  // Status of group g given its op_en bit and the current consumer pointer.
  function automatic logic [1:0] grp_status(input logic op_en, input logic consumer,
                                            input logic g);
    logic [1:0] st;
    st = IDLE;
    if (op_en) begin
      st = (consumer == g) ? RUNNING : PENDING;
    end
    return st;
  endfunction

endpackage

// File: rtl/rbk_group_ctrl.sv
// Ping-pong group controller: tracks per-group op_en, routes CSB writes to the
// producer group, launches/retires layers on the core. Strobes are 0-latency.
module rbk_group_ctrl
  import rbk_grp_pkg::*;
#(
  parameter logic [11:0] OP_EN_OFFSET = DEF_OP_EN_OFFSET,
  parameter logic [11:0] GRP_FIRST    = DEF_GRP_FIRST,
  parameter logic [11:0] GRP_LAST     = DEF_GRP_LAST
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic [11:0] reg_offset,
  input  logic [31:0] reg_wr_data,
  input  logic        reg_wr_en,
  input  logic        producer,
  input  logic        dp2reg_done,
  output logic        consumer,
  output logic [1:0]  status_0,
  output logic [1:0]  status_1,
  output logic        reg2dp_op_en,
  output logic        reg_wr_en_g0,
  output logic        reg_wr_en_g1,
  output logic        err_done_unexp,
  output logic        err_wr_blocked
);

  grp_state_e state_q, state_d;
  logic [1:0] op_en_q, op_en_d;
  logic       consumer_q, consumer_d;
  logic       op_en_out_q, op_en_out_d;
  logic       err_done_q, err_done_d;
  logic       err_wr_q, err_wr_d;

  logic       in_grp;
  logic       is_op_en;
  logic       op_wr;
  logic [1:0] prod_status;
  logic [1:0] grp_pass;
  logic       unused_wr_data;

  assign unused_wr_data = ^reg_wr_data[31:1];

  assign in_grp   = (reg_offset >= GRP_FIRST) && (reg_offset <= GRP_LAST);
  assign is_op_en = (reg_offset == OP_EN_OFFSET);
  assign op_wr    = reg_wr_en && is_op_en;

  assign prod_status = grp_status(op_en_q[producer], consumer_q, producer);

  // The op_en register itself stays writable while its group is enabled.
  assign grp_pass[0] = !op_en_q[0] || is_op_en;
  assign grp_pass[1] = !op_en_q[1] || is_op_en;

  assign reg_wr_en_g0 = reg_wr_en && in_grp && (producer == 1'b0) && grp_pass[0];
  assign reg_wr_en_g1 = reg_wr_en && in_grp && (producer == 1'b1) && grp_pass[1];

  always_comb begin
    state_d     = state_q;
    op_en_d     = op_en_q;
    consumer_d  = consumer_q;
    op_en_out_d = op_en_out_q;
    err_done_d  = err_done_q;
    err_wr_d    = err_wr_q;

    if (reg_wr_en && in_grp && !grp_pass[producer]) begin
      err_wr_d = 1'b1;
    end

    if (op_wr) begin
      if (reg_wr_data[0]) begin
        op_en_d[producer] = 1'b1;
      end else if (prod_status != RUNNING) begin
        op_en_d[producer] = 1'b0;
      end
    end

    // Done retirement is applied after the op_en write so that it wins.
    case (state_q)
      S_IDLE: begin
        if (dp2reg_done) begin
          err_done_d = 1'b1;
        end
        if (op_en_q[consumer_q]) begin
          state_d     = S_RUN;
          op_en_out_d = 1'b1;
        end
      end
      S_RUN: begin
        if (dp2reg_done) begin
          op_en_d[consumer_q] = 1'b0;
          consumer_d          = !consumer_q;
          op_en_out_d         = 1'b0;
          state_d             = S_GAP;
        end
      end
      S_GAP: begin
        if (dp2reg_done) begin
          err_done_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        op_en_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= S_IDLE;
      op_en_q     <= 2'b00;
      consumer_q  <= 1'b0;
      op_en_out_q <= 1'b0;
      err_done_q  <= 1'b0;
      err_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_en_q     <= op_en_d;
      consumer_q  <= consumer_d;
      op_en_out_q <= op_en_out_d;
      err_done_q  <= err_done_d;
      err_wr_q    <= err_wr_d;
    end
  end

  assign consumer       = consumer_q;
  assign status_0       = grp_status(op_en_q[0], consumer_q, 1'b0);
  assign status_1       = grp_status(op_en_q[1], consumer_q, 1'b1);
  assign reg2dp_op_en   = op_en_out_q;
  assign err_done_unexp = err_done_q;
  assign err_wr_blocked = err_wr_q;

endmodule

// File: tb/tb_rbk_group_ctrl.sv
// Directed vector bench for rbk_group_ctrl: one vector per clock cycle,
// strobes checked before the edge, registered outputs checked after it.
module tb_rbk_group_ctrl;

  logic        clk;
  logic        rstn;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        producer;
  logic        dp2reg_done;
  logic        consumer;
  logic [1:0]  status_0;
  logic [1:0]  status_1;
  logic        reg2dp_op_en;
  logic        reg_wr_en_g0;
  logic        reg_wr_en_g1;
  logic        err_done_unexp;
  logic        err_wr_blocked;

  int checks = 0;
  int errors = 0;

  rbk_group_ctrl dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .reg_offset     (reg_offset),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .producer       (producer),
    .dp2reg_done    (dp2reg_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .reg2dp_op_en   (reg2dp_op_en),
    .reg_wr_en_g0   (reg_wr_en_g0),
    .reg_wr_en_g1   (reg_wr_en_g1),
    .err_done_unexp (err_done_unexp),
    .err_wr_blocked (err_wr_blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] off;
    logic        dat;
    logic        prod;
    logic        done;
    logic        e_g0;
    logic        e_g1;
    logic        e_cons;
    logic [1:0]  e_s0;
    logic [1:0]  e_s1;
    logic        e_op;
    logic        e_ed;
    logic        e_ew;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic wr, input logic [11:0] off, input logic dat,
                              input logic prod, input logic done, input logic g0,
                              input logic g1, input logic cons, input logic [1:0] s0,
                              input logic [1:0] s1, input logic op, input logic ed,
                              input logic ew);
    vec_t v;
    v.wr = wr; v.off = off; v.dat = dat; v.prod = prod; v.done = done;
    v.e_g0 = g0; v.e_g1 = g1; v.e_cons = cons; v.e_s0 = s0; v.e_s1 = s1;
    v.e_op = op; v.e_ed = ed; v.e_ew = ew;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    reg_wr_en   = 1'b0;
    reg_offset  = 12'h000;
    reg_wr_data = 32'h0;
    producer    = 1'b0;
    dp2reg_done = 1'b0;
  endtask

  initial begin
    //                wr off     d  p  dn  g0 g1 cn s0 s1 op ed ew
    vecs[0]  = mk(0, 12'h000, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0); // reset state
    vecs[1]  = mk(1, 12'h008, 1, 0, 0,  1, 0,  0, 1, 0, 0, 0, 0); // enable g0
    vecs[2]  = mk(0, 12'h000, 0, 0, 0,  0, 0,  0, 1, 0, 1, 0, 0); // launch
    vecs[3]  = mk(1, 12'h010, 0, 0, 0,  0, 0,  0, 1, 0, 1, 0, 1); // blocked g0 write
    vecs[4]  = mk(1, 12'h010, 0, 1, 0,  0, 1,  0, 1, 0, 1, 0, 1); // idle g1 passes
    vecs[5]  = mk(1, 12'h008, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 1); // clear running: ignored
    vecs[6]  = mk(1, 12'h008, 1, 1, 0,  0, 1,  0, 1, 2, 1, 0, 1); // g1 pending
    vecs[7]  = mk(1, 12'h008, 0, 1, 0,  0, 1,  0, 1, 0, 1, 0, 1); // clear pending g1
    vecs[8]  = mk(1, 12'h008, 1, 1, 0,  0, 1,  0, 1, 2, 1, 0, 1); // g1 pending again
    vecs[9]  = mk(0, 12'h000, 0, 0, 1,  0, 0,  1, 0, 1, 0, 0, 1); // done -> swap
    vecs[10] = mk(0, 12'h000, 0, 0, 0,  0, 0,  1, 0, 1, 0, 0, 1); // gap, still low
    vecs[11] = mk(0, 12'h000, 0, 0, 0,  0, 0,  1, 0, 1, 1, 0, 1); // relaunch g1
    vecs[12] = mk(1, 12'h100, 1, 0, 0,  0, 0,  1, 0, 1, 1, 0, 1); // above group space
    vecs[13] = mk(1, 12'h004, 1, 0, 0,  0, 0,  1, 0, 1, 1, 0, 1); // below group space
    vecs[14] = mk(1, 12'h0FC, 1, 0, 0,  1, 0,  1, 0, 1, 1, 0, 1); // last offset
    vecs[15] = mk(1, 12'h008, 1, 0, 1,  1, 0,  0, 1, 0, 0, 0, 1); // done + set other
    vecs[16] = mk(0, 12'h000, 0, 0, 0,  0, 0,  0, 1, 0, 0, 0, 1); // gap
    vecs[17] = mk(0, 12'h000, 0, 0, 1,  0, 0,  0, 1, 0, 1, 1, 1); // done in S_IDLE
    vecs[18] = mk(1, 12'h008, 0, 0, 1,  1, 0,  1, 0, 0, 0, 1, 1); // done wins over clear
    vecs[19] = mk(1, 12'h008, 1, 1, 0,  0, 1,  1, 0, 1, 0, 1, 1); // enable g1
    vecs[20] = mk(0, 12'h000, 0, 0, 0,  0, 0,  1, 0, 1, 1, 1, 1); // launch g1
    vecs[21] = mk(0, 12'h000, 0, 0, 0,  0, 0,  1, 0, 1, 1, 1, 1);
    vecs[22] = mk(1, 12'h008, 1, 0, 0,  1, 0,  1, 2, 1, 1, 1, 1); // g0 pending

    drive_idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reg_wr_en   = vecs[i].wr;
      reg_offset  = vecs[i].off;
      reg_wr_data = {31'h0, vecs[i].dat};
      producer    = vecs[i].prod;
      dp2reg_done = vecs[i].done;
      #1;
      chk("reg_wr_en_g0", i, {31'h0, reg_wr_en_g0}, {31'h0, vecs[i].e_g0});
      chk("reg_wr_en_g1", i, {31'h0, reg_wr_en_g1}, {31'h0, vecs[i].e_g1});
      @(posedge clk);
      #1;
      chk("consumer", i, {31'h0, consumer}, {31'h0, vecs[i].e_cons});
      chk("status_0", i, {30'h0, status_0}, {30'h0, vecs[i].e_s0});
      chk("status_1", i, {30'h0, status_1}, {30'h0, vecs[i].e_s1});
      chk("reg2dp_op_en", i, {31'h0, reg2dp_op_en}, {31'h0, vecs[i].e_op});
      chk("err_done_unexp", i, {31'h0, err_done_unexp}, {31'h0, vecs[i].e_ed});
      chk("err_wr_blocked", i, {31'h0, err_wr_blocked}, {31'h0, vecs[i].e_ew});
    end

    // Asynchronous reset while group 1 runs and group 0 is pending.
    @(negedge clk);
    drive_idle();
    rstn = 1'b0;
    #1;
    chk("rst_consumer", 100, {31'h0, consumer}, 32'h0);
    chk("rst_status_0", 100, {30'h0, status_0}, 32'h0);
    chk("rst_status_1", 100, {30'h0, status_1}, 32'h0);
    chk("rst_op_en", 100, {31'h0, reg2dp_op_en}, 32'h0);
    chk("rst_err_done", 100, {31'h0, err_done_unexp}, 32'h0);
    chk("rst_err_wr", 100, {31'h0, err_wr_blocked}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Nothing should launch, and a done must be treated as unexpected.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_op_en", 101 + c, {31'h0, reg2dp_op_en}, 32'h0);
    end
    @(negedge clk);
    dp2reg_done = 1'b1;
    @(posedge clk);
    #1;
    dp2reg_done = 1'b0;
    chk("post_rst_done_consumer", 110, {31'h0, consumer}, 32'h0);
    chk("post_rst_done_err", 110, {31'h0, err_done_unexp}, 32'h1);
    chk("post_rst_done_op_en", 110, {31'h0, reg2dp_op_en}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
